// File: rtl/abro_scheduler_if.sv
// Requester-side bundle of the ABRO scheduler: per-requester session requests,
// event lines and the grant/completion pulses returned to them.
interface abro_scheduler_if #(
  parameter int unsigned N_REQ = 4
) ();
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] req_a;
  logic [N_REQ-1:0] req_b;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] timeout_err;

  modport master (
    output req, req_a, req_b,
    input  grant, done, timeout_err
  );

  modport slave (
    input  req, req_a, req_b,
    output grant, done, timeout_err
  );
endinterface

// File: rtl/abro_scheduler.sv
// Round-robin scheduler sharing a single ABRO engine among N_REQ requesters: one
// session per grant (clear engine, forward A/B, await O or timeout, report).
module abro_scheduler #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  abro_scheduler_if.slave        req_bus,
  output logic                   busy,
  output logic [2:0]             state,
  output logic                   abro_rst,
  output logic                   abro_a,
  output logic                   abro_b,
  input  logic                   abro_o
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StArb    = 3'd1,
    StClr    = 3'd2,
    StRun    = 3'd3,
    StReport = 3'd4
  } state_e;

  localparam int unsigned SelW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  state_e          state_q, state_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [SelW-1:0] last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ok_q, ok_d;
  logic            clr_q, clr_d;

  logic            found;
  logic [SelW-1:0] pick;
  logic [SelW-1:0] idx;

  // First requester after last, wrapping; the last slot checked is last itself.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx = SelW'((32'(last_q) + i) % N_REQ);
      if (!found && req_bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ok_d    = ok_q;
    clr_d   = clr_q;
    unique case (state_q)
      StIdle: begin
        if (|req_bus.req) state_d = StArb;
      end
      StArb: begin
        if (found) begin
          sel_d   = pick;
          clr_d   = 1'b0;
          state_d = StClr;
        end else begin
          state_d = StIdle;
        end
      end
      StClr: begin
        cnt_d = '0;
        // Engine reset is held for exactly two cycles.
        if (clr_q) state_d = StRun;
        else       clr_d   = 1'b1;
      end
      StRun: begin
        if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
        if (abro_o) begin
          ok_d    = 1'b1;
          state_d = StReport;
        end else if (cnt_q == CntLast) begin
          ok_d    = 1'b0;
          state_d = StReport;
        end else if (!req_bus.req[sel_q]) begin
          last_d  = sel_q;
          state_d = StIdle;
        end
      end
      StReport: begin
        last_d  = sel_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      sel_q   <= '0;
      last_q  <= SelW'(N_REQ - 1);
      cnt_q   <= '0;
      ok_q    <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ok_q    <= ok_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    req_bus.grant       = '0;
    req_bus.done        = '0;
    req_bus.timeout_err = '0;
    abro_rst            = 1'b1;
    abro_a              = 1'b0;
    abro_b              = 1'b0;
    unique case (state_q)
      StClr: begin
        req_bus.grant[sel_q] = 1'b1;
      end
      StRun: begin
        req_bus.grant[sel_q] = 1'b1;
        abro_rst             = 1'b0;
        abro_a               = req_bus.req_a[sel_q];
        abro_b               = req_bus.req_b[sel_q];
      end
      StReport: begin
        req_bus.grant[sel_q] = 1'b1;
        abro_rst             = 1'b0;
        if (ok_q) req_bus.done[sel_q]        = 1'b1;
        else      req_bus.timeout_err[sel_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy  = (state_q != StIdle);
  assign state = state_q;

endmodule

// File: tb/tb_abro_scheduler.sv
// Directed bench for abro_scheduler: a per-cycle vector table for a full success
// session plus hand-written timeout, round-robin, abort and async-reset sequences.
module tb_abro_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       busy;
  logic [2:0] state;
  logic       abro_rst;
  logic       abro_a;
  logic       abro_b;
  logic       abro_o;

  int n_vec = 0;
  int n_bad = 0;

  abro_scheduler_if #(.N_REQ(4)) req_bus ();

  abro_scheduler #(
    .N_REQ  (4),
    .TIMEOUT(16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req_bus (req_bus),
    .busy    (busy),
    .state   (state),
    .abro_rst(abro_rst),
    .abro_a  (abro_a),
    .abro_b  (abro_b),
    .abro_o  (abro_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] ra;
    logic [3:0] rb;
    logic       o;
    logic [2:0] st;
    logic [3:0] gnt;
    logic [3:0] dn;
    logic [3:0] te;
    logic       rst;
    logic       a;
    logic       b;
  } vec_t;

  vec_t vec [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] e_st, input logic [3:0] e_gnt,
                       input logic [3:0] e_dn, input logic [3:0] e_te, input logic e_rst,
                       input logic e_a, input logic e_b);
    logic [18:0] act;
    logic [18:0] exp;
    act = {state, busy, req_bus.grant, req_bus.done, req_bus.timeout_err, abro_rst, abro_a,
           abro_b};
    exp = {e_st, (e_st != 3'd0), e_gnt, e_dn, e_te, e_rst, e_a, e_b};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got st=%0d busy=%b gnt=%b done=%b terr=%b rst=%b a=%b b=%b, want st=%0d busy=%b gnt=%b done=%b terr=%b rst=%b a=%b b=%b",
               name, act[18:16], act[15], act[14:11], act[10:7], act[6:3], act[2], act[1],
               act[0], exp[18:16], exp[15], exp[14:11], exp[10:7], exp[6:3], exp[2], exp[1],
               exp[0]);
    end
  endtask

  task automatic reset_dut();
    req_bus.req   = '0;
    req_bus.req_a = '0;
    req_bus.req_b = '0;
    abro_o        = 1'b0;
    reset         = 1'b0;
    @(posedge clk);
    #2;
    check("reset", 3'd0, 4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  // Runs one session with req held at 4'b1111; engine reports O on the first RUN cycle.
  task automatic session(input int unsigned idx);
    logic [3:0]  oh;
    int unsigned n;
    oh = 4'b0001 << idx;
    n  = 0;
    do begin
      tick();
      n++;
    end while (state != 3'd3 && n < 8);
    check($sformatf("rr%0d_run", idx), 3'd3, oh, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    abro_o = 1'b1;
    tick();
    abro_o = 1'b0;
    check($sformatf("rr%0d_done", idx), 3'd4, oh, oh, 4'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check($sformatf("rr%0d_gap", idx), 3'd0, 4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // req, ra, rb, o | st, gnt, done, terr, rst, a, b
    vec[0]  = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 3'd0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};
    vec[1]  = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 3'd1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};
    vec[2]  = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 3'd2, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};
    vec[3]  = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 3'd2, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};
    vec[4]  = '{4'b0001, 4'b0001, 4'b0000, 1'b0, 3'd3, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0};
    vec[5]  = '{4'b0001, 4'b0000, 4'b0001, 1'b0, 3'd3, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1};
    vec[6]  = '{4'b0001, 4'b0000, 4'b0000, 1'b1, 3'd3, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    vec[7]  = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 3'd4, 4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0};
    vec[8]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};
    vec[9]  = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 3'd0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};
    vec[10] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};
    vec[11] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};
    vec[12] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};

    reset_dut();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_noreq", 3'd0, 4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0);
    end

    // Success session, then a request that vanishes during ARB.
    for (int i = 0; i < 13; i++) begin
      req_bus.req   = vec[i].req;
      req_bus.req_a = vec[i].ra;
      req_bus.req_b = vec[i].rb;
      abro_o        = vec[i].o;
      #1;
      check($sformatf("tbl%0d", i), vec[i].st, vec[i].gnt, vec[i].dn, vec[i].te, vec[i].rst,
            vec[i].a, vec[i].b);
      tick();
    end
    req_bus.req_a = '0;
    req_bus.req_b = '0;
    abro_o        = 1'b0;

    // Timeout: requester 1 with A/B idle for all 16 RUN cycles.
    req_bus.req = 4'b0010;
    #1;
    check("to_idle", 3'd0, 4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("to_arb", 3'd1, 4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("to_clr0", 3'd2, 4'b0010, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("to_clr1", 3'd2, 4'b0010, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("to_run%0d", k), 3'd3, 4'b0010, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    check("to_report", 3'd4, 4'b0010, 4'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    req_bus.req = 4'b0000;
    tick();
    check("to_after", 3'd0, 4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0);

    // Round-robin with every requester asking.
    reset_dut();
    req_bus.req = 4'b1111;
    session(0);
    session(1);
    session(2);
    session(3);
    session(0);

    // Abort: requester 0 drops its request in the 3rd RUN cycle.
    reset_dut();
    req_bus.req = 4'b0001;
    for (int k = 0; k < 4; k++) tick();
    check("ab_run1", 3'd3, 4'b0001, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("ab_run2", 3'd3, 4'b0001, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    tick();
    req_bus.req = 4'b0010;
    #1;
    check("ab_run3", 3'd3, 4'b0001, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("ab_idle", 3'd0, 4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("ab_arb", 3'd1, 4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0);
    tick();
    // last was updated on abort, so requester 1 is next.
    check("ab_next", 3'd2, 4'b0010, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a RUN session.
    reset_dut();
    req_bus.req = 4'b0001;
    for (int k = 0; k < 4; k++) tick();
    check("ar_run", 3'd3, 4'b0001, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    reset = 1'b0;
    #1;
    check("ar_async", 3'd0, 4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0);
    req_bus.req = 4'b0000;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("ar_post%0d", k), 3'd0, 4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/abro_scheduler.md
# abro_scheduler

Round-robin scheduler that shares one ABRO sequence-detector engine among N_REQ requesters. Each granted requester gets its own session: the scheduler clears the engine, forwards that requester's A/B event lines, and waits for the engine's O output or a timeout. It then reports success or timeout back to the requester and moves on. The block sits between the requester-side event sources and the single ABRO instance (ports clk, reset, A, B, O).

## Interface
- N_REQ, 4: number of requesters (2..8).
- TIMEOUT, 16: maximum RUN cycles per session before an error is reported (2..255).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req  in  N_REQ  per-requester session request; level, held until done/timeout_err.
- req_a  in  N_REQ  per-requester A event line.
- req_b  in  N_REQ  per-requester B event line.
- grant  out  N_REQ  one-hot owner of the engine; all zero when no owner.
- done  out  N_REQ  one-cycle pulse: owner's session saw O=1.
- timeout_err  out  N_REQ  one-cycle pulse: owner's session timed out.
- busy  out  1  high whenever the FSM is not in IDLE.
- state  out  3  FSM state code, for debug.
- abro_rst  out  1  active-high reset to the engine.
- abro_a  out  1  A input to the engine.
- abro_b  out  1  B input to the engine.
- abro_o  in  1  O output from the engine.

## Operation
- FSM states: IDLE=0, ARB=1, CLR=2, RUN=3, REPORT=4.
- IDLE: abro_rst=1, grant=0. Go to ARB when any req bit is high.
- ARB: search req from index last+1 upward, wrapping modulo N_REQ. Register the first set index as sel. Go to CLR. If req has dropped to all zero, return to IDLE.
- CLR: grant[sel]=1, abro_rst=1 for exactly 2 cycles. Clear cnt to 0. Go to RUN.
- RUN: abro_rst=0, abro_a=req_a[sel], abro_b=req_b[sel] (combinational from the registered state and sel). cnt increments each cycle.
  - abro_o=1: go to REPORT with ok=1.
  - cnt==TIMEOUT-1 and abro_o=0: go to REPORT with ok=0.
  - req[sel]=0: abort to IDLE with no pulse. last is still updated to sel.
- REPORT: abro_rst=0, abro_a=abro_b=0. Pulse done[sel] if ok, else timeout_err[sel], for 1 cycle. Set last=sel. Go to IDLE.
- abro_a/abro_b are 0 in every state except RUN.
- cnt width is clog2(TIMEOUT)+1 and never wraps; it is held once the FSM leaves RUN.
- If O=1 and the timeout condition occur in the same cycle, success wins.
- Requests from non-owners are ignored until the next ARB. A pending req is never dropped: fairness is round-robin by the last pointer.

## Timing
- Reset values: state=IDLE, grant=0, done=0, timeout_err=0, busy=0, abro_rst=1, abro_a=abro_b=0, last=N_REQ-1 (so requester 0 wins first), sel=0, cnt=0, ok=0.
- Reset low mid-session: returns to IDLE immediately (asynchronously) with the values above. No done or timeout_err pulse is issued.
- Cycle numbering, with req rising before edge 0 while in IDLE:
  - Edge 0: ARB.
  - Edges 1–2: CLR.
  - Edge 3: RUN.
  - The first forwarded A/B is visible in the cycle after edge 3.
- abro_o is sampled at edge k in RUN; REPORT follows at edge k and done is high for the cycle after edge k; IDLE follows at edge k+1.
- Worst-case session is 2+2+TIMEOUT+1 cycles, IDLE to IDLE.
- Back-to-back sessions: minimum one IDLE cycle between REPORT and the next ARB.

## Test plan
- Reset: hold reset=0 → grant=0, abro_rst=1, busy=0, state=0. Release, req=0 → FSM stays in IDLE.
- Single success: req=4'b0001; req_a=1 on the 1st RUN cycle, req_b=1 on the 2nd; model O high 1 cycle after both are seen → done=4'b0001 for exactly 1 cycle, no timeout_err.
- Timeout: req=4'b0010, A/B held 0, TIMEOUT=16 → after 16 RUN cycles timeout_err=4'b0010 for 1 cycle; then IDLE.
- Round-robin: req=4'b1111 held, each session completing → grant order 0,1,2,3,0. No requester is granted twice before all others.
- Abort: drop req[sel] in the 3rd RUN cycle → next state IDLE, no done or timeout_err pulse, abro_rst=1 the following cycle.
- Async reset mid-RUN: pull reset=0 between edges → state=0 and abro_rst=1 before the next edge; no pulses after release.
